// File: rtl/stream_output_pkg.sv
// Shared encodings and field layout for the engine-to-host result stream:
// FSM states, trailer magic, pad record and record/trailer packing helpers.
package stream_output_pkg;

  typedef enum logic [3:0] {
    FILL_LO      = 4'b0001,
    FILL_HI      = 4'b0010,
    SEND_DATA    = 4'b0100,
    SEND_TRAILER = 4'b1000
  } state_t;

  localparam int POS_W   = 25;
  localparam int SCORE_W = 16;
  localparam int QCNT_W  = 16;
  localparam int RCNT_W  = 32;
  localparam int REC_W   = 64;
  localparam int DATA_W  = 128;

  localparam logic [31:0]      TRAILER_MAGIC = 32'h5357_454E;
  // Bits [31:25] of a real record are always zero, so all-ones can never collide.
  localparam logic [REC_W-1:0] PAD_RECORD    = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int REC_POS_LSB   = 0;
  localparam int REC_SCORE_LSB = 32;
  localparam int REC_QCNT_LSB  = 48;

  localparam int TRL_MAGIC_LSB = 0;
  localparam int TRL_QCNT_LSB  = 32;
  localparam int TRL_RCNT_LSB  = 64;

  function automatic logic [REC_W-1:0] make_record(input logic [QCNT_W-1:0]  qcnt,
                                                   input logic [SCORE_W-1:0] score,
                                                   input logic [POS_W-1:0]   pos);
    logic [REC_W-1:0] rec;
    rec = '0;
    rec[REC_POS_LSB +: POS_W]     = pos;
    rec[REC_SCORE_LSB +: SCORE_W] = score;
    rec[REC_QCNT_LSB +: QCNT_W]   = qcnt;
    return rec;
  endfunction

  function automatic logic [DATA_W-1:0] make_trailer(input logic [QCNT_W-1:0] qcnt,
                                                     input logic [RCNT_W-1:0] rcnt);
    logic [DATA_W-1:0] trl;
    trl = '0;
    trl[TRL_MAGIC_LSB +: 32]    = TRAILER_MAGIC;
    trl[TRL_QCNT_LSB +: QCNT_W] = qcnt;
    trl[TRL_RCNT_LSB +: RCNT_W] = rcnt;
    return trl;
  endfunction

endpackage

// File: rtl/stream_output_handler_if.sv
// Result input port and stream output port of the handler. Both sides use
// valid/ready: a beat or word transfers on a clock edge where valid and ready are both 1.
interface stream_output_handler_if;
  import stream_output_pkg::*;

  logic               result_valid_in;
  logic               result_rdy_out;
  logic [POS_W-1:0]   result_ref_pos_in;
  logic [SCORE_W-1:0] result_score_in;
  logic               result_null_in;
  logic               result_last_in;

  logic               so_valid;
  logic [DATA_W-1:0]  so_data;
  logic               so_rdy;

  modport master (
    input  result_valid_in, result_ref_pos_in, result_score_in,
           result_null_in, result_last_in, so_rdy,
    output result_rdy_out, so_valid, so_data
  );

  modport slave (
    output result_valid_in, result_ref_pos_in, result_score_in,
           result_null_in, result_last_in, so_rdy,
    input  result_rdy_out, so_valid, so_data
  );

endinterface

// File: rtl/so_output_reg.sv
// 128-bit output holding register: load sets valid with new data, a handshake
// clears valid; load wins so a trailer can follow a data word back to back.
module so_output_reg
  import stream_output_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              rdy,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && rdy) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_output_handler.sv
// Packs two 64-bit hit records per 128-bit output word and closes every query
// with a trailer word carrying the query number and its record count.
module stream_output_handler
  import stream_output_pkg::*;
#(
  parameter logic [QCNT_W-1:0] QUERY_CNT_INIT = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  stream_output_handler_if.master bus,
  output state_t                  dbg_state
);

  state_t            state, state_nxt;
  logic [REC_W-1:0]  lo_q, lo_nxt;
  logic              trailer_pend, pend_nxt;
  logic [QCNT_W-1:0] query_cnt;
  logic [RCNT_W-1:0] rec_cnt;

  logic              accept, so_hs, load;
  logic [DATA_W-1:0] load_data;
  logic [REC_W-1:0]  cur_rec;
  logic [DATA_W-1:0] trailer;

  assign bus.result_rdy_out = !rst && (state == FILL_LO || state == FILL_HI);
  assign accept    = bus.result_valid_in && bus.result_rdy_out;
  assign so_hs     = bus.so_valid && bus.so_rdy;
  assign cur_rec   = make_record(query_cnt, bus.result_score_in, bus.result_ref_pos_in);
  assign trailer   = make_trailer(query_cnt, rec_cnt);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL_LO;
      lo_q         <= '0;
      trailer_pend <= 1'b0;
    end else begin
      state        <= state_nxt;
      lo_q         <= lo_nxt;
      trailer_pend <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lo_nxt    = lo_q;
    pend_nxt  = trailer_pend;
    load      = 1'b0;
    load_data = {PAD_RECORD, cur_rec};
    case (state)
      FILL_LO: if (accept) begin
        if (bus.result_null_in) begin
          if (bus.result_last_in) begin
            load      = 1'b1;
            load_data = trailer;
            state_nxt = SEND_TRAILER;
          end
        end else if (bus.result_last_in) begin
          load      = 1'b1;
          pend_nxt  = 1'b1;
          state_nxt = SEND_DATA;
        end else begin
          lo_nxt    = cur_rec;
          state_nxt = FILL_HI;
        end
      end
      // A null beat here still closes the half-filled word with a pad record.
      FILL_HI: if (accept) begin
        load      = 1'b1;
        load_data = {(bus.result_null_in ? PAD_RECORD : cur_rec), lo_q};
        pend_nxt  = bus.result_last_in;
        state_nxt = SEND_DATA;
      end
      SEND_DATA: if (so_hs) begin
        pend_nxt = 1'b0;
        if (trailer_pend) begin
          load      = 1'b1;
          load_data = trailer;
          state_nxt = SEND_TRAILER;
        end else begin
          state_nxt = FILL_LO;
        end
      end
      SEND_TRAILER: if (so_hs) state_nxt = FILL_LO;
      default: state_nxt = FILL_LO;
    endcase
  end

  // The trailer is built from the counters before this update takes effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      query_cnt <= QUERY_CNT_INIT;
      rec_cnt   <= '0;
    end else if (state == SEND_TRAILER && so_hs) begin
      query_cnt <= query_cnt + 16'd1;
      rec_cnt   <= '0;
    end else if (accept && !bus.result_null_in) begin
      rec_cnt   <= rec_cnt + 32'd1;
    end
  end

  so_output_reg u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .rdy       (bus.so_rdy),
    .valid     (bus.so_valid),
    .data      (bus.so_data)
  );

endmodule

// File: tb/tb_stream_output_handler.sv
// Directed bench for stream_output_handler: expected words are hand-computed
// constants queued in order and compared on every output handshake.
module tb_stream_output_handler;
  import stream_output_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state, dbg_state_w;
  int     checks = 0;
  int     errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] mon_exp;
  logic [127:0] exp_wrap[4];
  logic [127:0] bp_word;

  stream_output_handler_if bus();
  stream_output_handler_if bus_w();

  stream_output_handler dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  stream_output_handler #(.QUERY_CNT_INIT(16'hFFFE)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_w),
    .dbg_state (dbg_state_w)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic send_beat(input logic [24:0] pos, input logic [15:0] score,
                           input logic is_null, input logic last);
    int n;
    n = 0;
    bus.result_valid_in   = 1'b1;
    bus.result_ref_pos_in = pos;
    bus.result_score_in   = score;
    bus.result_null_in    = is_null;
    bus.result_last_in    = last;
    @(negedge clk);
    while (!bus.result_rdy_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept", 128'(bus.result_rdy_out), 128'd1);
    @(posedge clk); #1;
    bus.result_valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_empty", 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (bus.so_valid && bus.so_rdy) begin
      if (exp_q.size() == 0) begin
        check("extra_word", bus.so_data, 128'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_word", bus.so_data, mon_exp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.result_valid_in   = 1'b1;
    bus.result_ref_pos_in = '0;
    bus.result_score_in   = '0;
    bus.result_null_in    = 1'b1;
    bus.result_last_in    = 1'b0;
    bus.so_rdy            = 1'b1;
    bus_w.result_valid_in   = 1'b0;
    bus_w.result_ref_pos_in = '0;
    bus_w.result_score_in   = '0;
    bus_w.result_null_in    = 1'b0;
    bus_w.result_last_in    = 1'b0;
    bus_w.so_rdy            = 1'b1;

    // reset held 3 cycles with valid asserted
    repeat (3) begin
      @(negedge clk);
      check("rst_rdy", 128'(bus.result_rdy_out), 128'd0);
      check("rst_so_valid", 128'(bus.so_valid), 128'd0);
      check("rst_so_data", bus.so_data, 128'd0);
    end
    check("rst_state", 128'(dbg_state), 128'(4'b0001));
    @(posedge clk); #1;
    rst = 1'b0;
    bus.result_valid_in = 1'b0;
    @(negedge clk);
    check("rel_rdy", 128'(bus.result_rdy_out), 128'd1);
    check("rel_so_valid", 128'(bus.so_valid), 128'd0);
    @(posedge clk); #1;

    // two records, query 0
    exp_q.push_back(128'h0000_0009_0000_0020_0000_0005_0000_0010);
    exp_q.push_back(128'h0000_0000_0000_0002_0000_0000_5357_454E);
    send_beat(25'h10, 16'd5, 1'b0, 1'b0);
    send_beat(25'h20, 16'd9, 1'b0, 1'b1);
    drain();

    // three records, query 1: second word padded
    exp_q.push_back(128'h0001_0022_0000_0200_0001_0011_0000_0100);
    exp_q.push_back(128'hFFFF_FFFF_FFFF_FFFF_0001_0033_0000_0300);
    exp_q.push_back(128'h0000_0000_0000_0003_0000_0001_5357_454E);
    send_beat(25'h100, 16'h11, 1'b0, 1'b0);
    send_beat(25'h200, 16'h22, 1'b0, 1'b0);
    send_beat(25'h300, 16'h33, 1'b0, 1'b1);
    drain();

    // zero-record query 2, then query 3 with a dropped null beat first
    exp_q.push_back(128'h0000_0000_0000_0000_0000_0002_5357_454E);
    send_beat(25'h0, 16'h0, 1'b1, 1'b1);
    drain();
    exp_q.push_back(128'hFFFF_FFFF_FFFF_FFFF_0003_0007_0000_0005);
    exp_q.push_back(128'h0000_0000_0000_0001_0000_0003_5357_454E);
    send_beat(25'h0, 16'h0, 1'b1, 1'b0);
    send_beat(25'h5, 16'h7, 1'b0, 1'b1);
    drain();

    // query 4: null mid-query in the high slot pads and continues
    exp_q.push_back(128'hFFFF_FFFF_FFFF_FFFF_0004_0001_0000_0040);
    exp_q.push_back(128'hFFFF_FFFF_FFFF_FFFF_0004_0002_0000_0041);
    exp_q.push_back(128'h0000_0000_0000_0002_0000_0004_5357_454E);
    send_beat(25'h40, 16'h1, 1'b0, 1'b0);
    send_beat(25'h0, 16'h0, 1'b1, 1'b0);
    send_beat(25'h41, 16'h2, 1'b0, 1'b1);
    drain();

    // query 5: max field values, closed by null&last in the high slot
    exp_q.push_back(128'hFFFF_FFFF_FFFF_FFFF_0005_FFFF_01FF_FFFF);
    exp_q.push_back(128'h0000_0000_0000_0001_0000_0005_5357_454E);
    send_beat(25'h1FF_FFFF, 16'hFFFF, 1'b0, 1'b0);
    send_beat(25'h0, 16'h0, 1'b1, 1'b1);
    drain();

    // query 6: backpressure for 10 cycles while the data word waits
    bp_word = 128'h0006_0080_0000_0008_0006_0070_0000_0007;
    exp_q.push_back(bp_word);
    exp_q.push_back(128'h0000_0000_0000_0002_0000_0006_5357_454E);
    bus.so_rdy = 1'b0;
    send_beat(25'h7, 16'h70, 1'b0, 1'b0);
    send_beat(25'h8, 16'h80, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 128'(bus.so_valid), 128'd1);
      check("bp_data", bus.so_data, bp_word);
      check("bp_rdy", 128'(bus.result_rdy_out), 128'd0);
    end
    @(posedge clk); #1;
    bus.so_rdy = 1'b1;
    drain();

    // reset with a half-filled word: it must vanish, counters restart
    send_beat(25'h99, 16'h1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_state", 128'(dbg_state), 128'(4'b0001));
    check("midrst_so_valid", 128'(bus.so_valid), 128'd0);
    @(posedge clk); #1;
    exp_q.push_back(128'h0000_000D_0000_000C_0000_000B_0000_000A);
    exp_q.push_back(128'h0000_0000_0000_0002_0000_0000_5357_454E);
    send_beat(25'hA, 16'hB, 1'b0, 1'b0);
    send_beat(25'hC, 16'hD, 1'b0, 1'b1);
    drain();

    // query counter wrap on the second instance starting at 0xFFFE
    exp_wrap[0] = 128'h0000_0000_0000_0000_0000_FFFE_5357_454E;
    exp_wrap[1] = 128'h0000_0000_0000_0000_0000_FFFF_5357_454E;
    exp_wrap[2] = 128'h0000_0000_0000_0000_0000_0000_5357_454E;
    exp_wrap[3] = 128'h0000_0000_0000_0000_0000_0001_5357_454E;
    bus_w.result_null_in  = 1'b1;
    bus_w.result_last_in  = 1'b1;
    bus_w.result_valid_in = 1'b1;
    begin
      int got, n;
      got = 0;
      n   = 0;
      while (got < 4 && n < 50) begin
        @(negedge clk);
        n++;
        if (bus_w.so_valid && bus_w.so_rdy) begin
          check("wrap_trailer", bus_w.so_data, exp_wrap[got]);
          got++;
        end
      end
      check("wrap_count", 128'(got), 128'd4);
    end
    @(posedge clk); #1;
    bus_w.result_valid_in = 1'b0;
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
